// File: rtl/blink_monitor.sv
// Protocol checker for a blinker's led/flg pins: locks onto the flg pulse train,
// measures the flg-to-flg period and flags the first protocol violation.
module blink_monitor #(
   parameter int CBITS = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             led,
   input  logic             flg,
   input  logic             clr,
   output logic             locked,
   output logic             err,
   output logic [2:0]       err_code,
   output logic [CBITS:0]   last_period,
   output logic [15:0]      pulses
);

   localparam logic [CBITS:0] PERIOD = {1'b1, {CBITS{1'b0}}};

   typedef enum logic [1:0] {
      SYNC,
      TRACK,
      FAULT
   } state_t;

   typedef enum logic [2:0] {
      ERR_NONE         = 3'd0,
      ERR_EARLY        = 3'd1,
      ERR_LATE         = 3'd2,
      ERR_LED_SPURIOUS = 3'd3,
      ERR_LED_MISSING  = 3'd4
   } err_t;

   state_t           state_q, state_d;
   logic [CBITS:0]   cnt_q, cnt_d;
   logic             led_q, flg_q;
   logic             locked_d, err_d;
   logic [2:0]       err_code_d;
   logic [CBITS:0]   last_period_d;
   logic [15:0]      pulses_d;

   logic             tog;
   logic [CBITS:0]   cnt_inc;
   err_t             fault;

   assign tog     = led ^ led_q;
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

   // Rule order matters: timing violations win over led violations.
   always_comb begin
      if (flg && (cnt_q < PERIOD))
         fault = ERR_EARLY;
      else if (!flg && (cnt_q == PERIOD))
         fault = ERR_LATE;
      else if (tog && !flg_q)
         fault = ERR_LED_SPURIOUS;
      else if (!tog && flg_q)
         fault = ERR_LED_MISSING;
      else
         fault = ERR_NONE;
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      locked_d      = locked;
      err_d         = err;
      err_code_d    = err_code;
      last_period_d = last_period;
      pulses_d      = pulses;

      if (clr) begin
         state_d    = SYNC;
         cnt_d      = '0;
         locked_d   = 1'b0;
         err_d      = 1'b0;
         err_code_d = ERR_NONE;
      end else begin
         unique case (state_q)
            SYNC: begin
               cnt_d = cnt_inc;
               if (flg) begin
                  cnt_d   = {{CBITS{1'b0}}, 1'b1};
                  state_d = TRACK;
               end
            end
            TRACK: begin
               cnt_d = cnt_inc;
               if (fault != ERR_NONE) begin
                  state_d    = FAULT;
                  err_d      = 1'b1;
                  err_code_d = fault;
                  locked_d   = 1'b0;
               end else if (flg && (cnt_q == PERIOD)) begin
                  last_period_d = cnt_q;
                  pulses_d      = (pulses == 16'hFFFF) ? pulses : pulses + 16'd1;
                  cnt_d         = {{CBITS{1'b0}}, 1'b1};
                  locked_d      = 1'b1;
               end
            end
            FAULT: ;
            default: state_d = SYNC;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= SYNC;
         cnt_q       <= '0;
         led_q       <= 1'b0;
         flg_q       <= 1'b0;
         locked      <= 1'b0;
         err         <= 1'b0;
         err_code    <= 3'd0;
         last_period <= '0;
         pulses      <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         led_q       <= led;
         flg_q       <= flg;
         locked      <= locked_d;
         err         <= err_d;
         err_code    <= err_code_d;
         last_period <= last_period_d;
         pulses      <= pulses_d;
      end
   end

endmodule

// File: tb/tb_blink_monitor.sv
// Bench for blink_monitor (CBITS=4): directed scenarios plus randomized rounds,
// all checked every cycle against a cycle-indexed behavioural model.
module tb_blink_monitor;

   localparam int CBITS  = 4;
   localparam int PERIOD = 16;

   localparam int K_NONE = 0, K_EARLY = 1, K_LATE = 2, K_SPUR = 3, K_MISS = 4;
   localparam int M_SYNC = 0, M_TRACK = 1, M_FAULT = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             led = 1'b0;
   logic             flg = 1'b0;
   logic             clr = 1'b0;
   logic             locked, err;
   logic [2:0]       err_code;
   logic [CBITS:0]   last_period;
   logic [15:0]      pulses;

   blink_monitor #(.CBITS(CBITS)) dut (
      .clk(clk), .rst(rst), .led(led), .flg(flg), .clr(clr),
      .locked(locked), .err(err), .err_code(err_code),
      .last_period(last_period), .pulses(pulses)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: time is a cycle index; the period is the distance to the last reference flg.
   int m_mode = M_SYNC, m_cyc = 0, m_ref = 0;
   bit m_pled = 0, m_pflg = 0;
   bit e_locked = 0, e_err = 0;
   int e_code = 0, e_last = 0, e_pulses = 0;

   task automatic model_reset();
      m_mode = M_SYNC; m_pled = 0; m_pflg = 0;
      e_locked = 0; e_err = 0; e_code = 0; e_last = 0; e_pulses = 0;
   endtask

   task automatic model_step(input bit l, input bit f, input bit c);
      int since, code;
      bit tg;
      if (!rst) begin
         model_reset();
      end else begin
         since = m_cyc - m_ref;
         tg    = (l != m_pled);
         if (c) begin
            m_mode = M_SYNC; e_err = 0; e_code = 0; e_locked = 0;
         end else if (m_mode == M_SYNC) begin
            if (f) begin
               m_mode = M_TRACK; m_ref = m_cyc;
            end
         end else if (m_mode == M_TRACK) begin
            code = (f && since < PERIOD)   ? K_EARLY :
                   (!f && since == PERIOD) ? K_LATE  :
                   (tg && !m_pflg)         ? K_SPUR  :
                   (!tg && m_pflg)         ? K_MISS  : 0;
            if (code != 0) begin
               m_mode = M_FAULT; e_err = 1; e_code = code; e_locked = 0;
            end else if (f) begin
               e_last   = since;
               e_pulses = (e_pulses >= 'hFFFF) ? 'hFFFF : e_pulses + 1;
               m_ref    = m_cyc;
               e_locked = 1;
            end
         end
      end
      m_pled = l; m_pflg = f; m_cyc++;
   endtask

   // Inputs change on the falling edge; the model then holds the post-rising-edge view.
   bit rst_next = 0;
   task automatic step(input bit l, input bit f, input bit c);
      @(negedge clk);
      rst = rst_next; led = l; flg = f; clr = c;
      model_step(l, f, c);
   endtask

   task automatic peek();
      @(posedge clk);
      #3;
   endtask

   // Blinker emulation: led toggles on the cycle after each flg unless suppressed.
   bit b_led = 0, b_prevf = 0;
   task automatic bcycle(input bit f, input bit extra, input bit no_tog, input bit c);
      bit l;
      l = b_led;
      if (b_prevf && !no_tog) l = ~l;
      if (extra) l = ~l;
      step(l, f, c);
      b_led = l; b_prevf = f;
   endtask

   task automatic period(input int kind, input int where, input int first);
      for (int i = first; i <= PERIOD; i++) begin
         bit f;
         f = (kind == K_EARLY) ? (i == where) : (kind == K_LATE) ? 1'b0 : (i == PERIOD);
         bcycle(f, (kind == K_SPUR) && (i == where), (kind == K_MISS) && (i == 1), 1'b0);
      end
   endtask

   task automatic idle(input int n, input bit rand_flg);
      for (int i = 0; i < n; i++) begin
         bit l, f;
         l = 1'($urandom_range(0, 1));
         f = rand_flg ? 1'($urandom_range(0, 1)) : 1'b0;
         step(l, f, 1'b0);
         b_led = l; b_prevf = f;
      end
   endtask

   task automatic fault_case(input int kind, input int where);
      bcycle(1'b0, 1'b0, 1'b0, 1'b1);
      period(K_NONE, 0, 1);
      period(K_NONE, 0, 1);
      period(kind, where, 1);
   endtask

   bit cmp_en = 1;
   always begin
      @(posedge clk);
      #2;
      if (cmp_en) begin
         check("locked",      32'(locked),      32'(e_locked));
         check("err",         32'(err),         32'(e_err));
         check("err_code",    32'(err_code),    32'(e_code));
         check("last_period", 32'(last_period), 32'(e_last));
         check("pulses",      32'(pulses),      32'(e_pulses));
      end
   end

   initial begin
      repeat (3) step(1'b0, 1'b0, 1'b0);
      peek();
      check("reset_locked", 32'(locked), 32'd0);
      check("reset_err_code", 32'(err_code), 32'd0);
      check("reset_pulses", 32'(pulses), 32'd0);
      rst_next = 1;

      // Ideal train of five flg pulses: four accepted periods.
      idle(3, 1'b0);
      repeat (5) period(K_NONE, 0, 1);
      peek();
      check("ideal_locked", 32'(locked), 32'd1);
      check("ideal_last", 32'(last_period), 32'd16);
      check("ideal_pulses", 32'(pulses), 32'd4);
      check("ideal_err", 32'(err), 32'd0);

      fault_case(K_EARLY, 15);
      peek();
      check("early_err", 32'(err), 32'd1);
      check("early_code", 32'(err_code), 32'd1);
      check("early_locked", 32'(locked), 32'd0);

      fault_case(K_LATE, 0);
      peek();
      check("late_code", 32'(err_code), 32'd2);
      check("late_last_frozen", 32'(last_period), 32'd16);

      fault_case(K_SPUR, 8);
      peek();
      check("spur_code", 32'(err_code), 32'd3);

      fault_case(K_MISS, 0);
      peek();
      check("miss_code", 32'(err_code), 32'd4);

      // clr with flg high while in FAULT: that flg must not start tracking.
      bcycle(1'b1, 1'b0, 1'b0, 1'b1);
      peek();
      check("clr_err", 32'(err), 32'd0);
      check("clr_code", 32'(err_code), 32'd0);
      period(K_NONE, 0, 1);
      peek();
      check("clr_flg_ignored", 32'(locked), 32'd0);
      period(K_NONE, 0, 1);
      peek();
      check("relock", 32'(locked), 32'd1);

      // Asynchronous reset in the middle of a period.
      period(K_NONE, 0, 1);
      @(posedge clk);
      #5;
      rst = 1'b0;
      rst_next = 0;
      model_reset();
      #1;
      check("async_locked", 32'(locked), 32'd0);
      check("async_last", 32'(last_period), 32'd0);
      check("async_pulses", 32'(pulses), 32'd0);
      bcycle(1'b0, 1'b0, 1'b0, 1'b0);
      bcycle(1'b0, 1'b0, 1'b0, 1'b0);
      rst_next = 1;

      // Saturation: preload the counter just below its maximum.
      idle(2, 1'b0);
      period(K_NONE, 0, 1);
      period(K_NONE, 0, 1);
      peek();
      force dut.pulses = 16'hFFFE;
      e_pulses = 'hFFFE;
      bcycle(1'b0, 1'b0, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      release dut.pulses;
      period(K_NONE, 0, 2);
      peek();
      check("sat_reach", 32'(pulses), 32'hFFFF);
      period(K_NONE, 0, 1);
      peek();
      check("sat_hold", 32'(pulses), 32'hFFFF);

      // Randomized rounds: random entry, random train length, random fault, noisy tail.
      for (int r = 0; r < 40; r++) begin
         int kind, where;
         bcycle(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
         idle($urandom_range(0, 20), 1'b0);
         period(K_NONE, 0, 1);
         repeat ($urandom_range(1, 4)) period(K_NONE, 0, 1);
         kind  = $urandom_range(0, 4);
         where = (kind == K_EARLY) ? $urandom_range(1, 15) : $urandom_range(2, 15);
         period(kind, where, 1);
         idle($urandom_range(0, 12), 1'b1);
      end

      @(negedge clk);
      cmp_en = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
